// File: rtl/pulse_timer.sv
// Tick-based countdown timer: a start pulse loads a duration, a prescaler divides
// clk into ticks, busy covers the count and done pulses once at normal expiry.
module pulse_timer #(
    parameter int CLK_DIV = 50000,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [CNT_W-1:0] duration,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   w_remaining_next;
    logic [PRE_W-1:0]   r_presc;
    logic [PRE_W-1:0]   w_presc_next;
    logic               w_tick;

    assign w_tick = (r_state == S_RUN) && (r_presc == PRE_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_presc     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_presc     <= w_presc_next;
        end
    end

    // Prescaler defaults to cleared; only a running count lets it advance.
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_presc_next     = '0;
        case (r_state)
            S_IDLE: begin
                if (!cancel && start) begin
                    if (duration != '0) begin
                        w_state_next     = S_RUN;
                        w_remaining_next = duration;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (cancel) begin
                    w_state_next     = S_IDLE;
                    w_remaining_next = '0;
                end else if (w_tick) begin
                    if (r_remaining == CNT_W'(1)) begin
                        w_state_next     = S_DONE;
                        w_remaining_next = '0;
                    end else begin
                        w_remaining_next = r_remaining - CNT_W'(1);
                    end
                end else begin
                    w_presc_next = r_presc + PRE_W'(1);
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next     = S_IDLE;
                w_remaining_next = '0;
            end
        endcase
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign remaining = r_remaining;

endmodule

// File: tb/tb_pulse_timer.sv
// Scoreboard bench for pulse_timer (CLK_DIV=4, CNT_W=8): stimulus queues expected
// per-cycle snapshots and done-pulse cycles; a monitor pops and compares them.
module tb_pulse_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cancel;
    logic [7:0] duration;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    pulse_timer #(.CLK_DIV(4), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cancel   (cancel),
        .duration (duration),
        .busy     (busy),
        .done     (done),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       busy;
        logic       done;
        logic [7:0] rem;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    exp_t e;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic expect_at(input int cyc, input logic b, input logic d,
                             input logic [7:0] r, input string name);
        exp_t x;
        x.cyc = cyc; x.busy = b; x.done = d; x.rem = r; x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: edge_cnt at a negedge is the number of the edge just passed.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
            e = exp_q.pop_front();
            checks++;
            if (e.cyc != edge_cnt || busy !== e.busy || done !== e.done || remaining !== e.rem) begin
                errors++;
                $display("FAIL %s cyc=%0d(exp %0d) got busy=%b done=%b rem=%0d expected busy=%b done=%b rem=%0d",
                         e.name, edge_cnt, e.cyc, busy, done, remaining, e.busy, e.done, e.rem);
            end else begin
                $display("ok   %s cyc=%0d busy=%b done=%b rem=%0d", e.name, edge_cnt, busy, done, remaining);
            end
        end
        if (done_q.size() > 0 && done_q[0] < edge_cnt) begin
            checks++;
            errors++;
            $display("FAIL done_missing expected_cyc=%0d got none (now %0d)", done_q[0], edge_cnt);
            void'(done_q.pop_front());
        end
        if (done !== 1'b0) begin
            checks++;
            if (done_q.size() > 0 && done_q[0] == edge_cnt) begin
                void'(done_q.pop_front());
                $display("ok   done_pulse cyc=%0d", edge_cnt);
            end else begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d got done=%b expected 0", edge_cnt, done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b1; cancel = 1'b0; duration = 8'd5;

        // 1: reset held two edges with start high
        expect_at(1, 0, 0, 0, "reset_e1");
        expect_at(2, 0, 0, 0, "reset_e2");
        expect_at(3, 0, 0, 0, "after_release");
        step(2);
        reset = 1'b0; start = 1'b0;
        step(2);

        // 2: duration 3 normal expiry
        n = edge_cnt + 1;
        start = 1'b1; duration = 8'd3;
        expect_at(n,      1, 0, 3, "d3_load");
        expect_at(n + 3,  1, 0, 3, "d3_hold");
        expect_at(n + 4,  1, 0, 2, "d3_dec1");
        expect_at(n + 7,  1, 0, 2, "d3_hold2");
        expect_at(n + 8,  1, 0, 1, "d3_dec2");
        expect_at(n + 11, 1, 0, 1, "d3_hold3");
        expect_at(n + 12, 0, 1, 0, "d3_done");
        expect_at(n + 13, 0, 0, 0, "d3_idle");
        done_q.push_back(n + 12);
        step(1); start = 1'b0;
        step(13);

        // 3: duration 5 cancelled at N+6
        n = edge_cnt + 1;
        start = 1'b1; duration = 8'd5;
        expect_at(n,      1, 0, 5, "cx_load");
        expect_at(n + 4,  1, 0, 4, "cx_dec");
        expect_at(n + 5,  1, 0, 4, "cx_precancel");
        expect_at(n + 6,  0, 0, 0, "cx_cancel");
        expect_at(n + 10, 0, 0, 0, "cx_idle");
        step(1); start = 1'b0;
        step(5); cancel = 1'b1;
        step(1); cancel = 1'b0;
        step(5);

        // 4: retrigger ignored while running
        n = edge_cnt + 1;
        start = 1'b1; duration = 8'd2;
        expect_at(n,     1, 0, 2, "rt_load");
        expect_at(n + 3, 1, 0, 2, "rt_ignored");
        expect_at(n + 4, 1, 0, 1, "rt_dec");
        expect_at(n + 7, 1, 0, 1, "rt_hold");
        expect_at(n + 8, 0, 1, 0, "rt_done");
        expect_at(n + 9, 0, 0, 0, "rt_idle");
        done_q.push_back(n + 8);
        step(1); start = 1'b0;
        step(2); start = 1'b1; duration = 8'd9;
        step(1); start = 1'b0;
        step(6);

        // 5: zero duration, start held into the DONE-exit edge, then start+cancel
        n = edge_cnt + 1;
        start = 1'b1; duration = 8'd0;
        expect_at(n,     0, 1, 0, "z_done");
        expect_at(n + 1, 0, 0, 0, "z_restart_ignored");
        expect_at(n + 2, 0, 0, 0, "z_idle");
        done_q.push_back(n);
        step(1); duration = 8'd3;
        step(1); start = 1'b0;
        step(1);
        n = edge_cnt + 1;
        start = 1'b1; cancel = 1'b1; duration = 8'd7;
        expect_at(n,     0, 0, 0, "sc_nothing");
        expect_at(n + 2, 0, 0, 0, "sc_idle");
        step(1); start = 1'b0; cancel = 1'b0;
        step(2);

        // 6: reset mid-count
        n = edge_cnt + 1;
        start = 1'b1; duration = 8'd4;
        expect_at(n,      1, 0, 4, "rs_load");
        expect_at(n + 4,  1, 0, 3, "rs_dec");
        expect_at(n + 5,  0, 0, 0, "rs_reset");
        expect_at(n + 10, 0, 0, 0, "rs_idle");
        expect_at(n + 20, 0, 0, 0, "rs_nodone");
        step(1); start = 1'b0;
        step(4); reset = 1'b1;
        step(1); reset = 1'b0;
        step(17);

        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_queue_drain got %0d pending expected 0", exp_q.size());
        end
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL done_queue_drain got %0d pending expected 0", done_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
